frame_sequencer: RTL and testbench
==================================

FRAME_SEQUENCER -- requirements
Module: frame_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock, all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port animation, input, 4 bits: selected animation index, 0..11 valid, 12..15 unused.
REQ-004 SHALL have port limit, input, 5 bits: frame count of current animation from the limit table; 31 means invalid animation.
REQ-005 SHALL have port run, input, 1 bit: 1 = advance frames, 0 = pause (hold frame and prescaler).
REQ-006 SHALL have port period, input, 16 bits: prescaler terminal count; tick interval = period+1 clk cycles.
REQ-007 SHALL have port frame, output, 5 bits: current frame index for the segment pattern ROM.
REQ-008 SHALL have port wrap, output, 1 bit: one-cycle pulse when frame returns to 0 via tick.
REQ-009 SHALL have port anim_change, output, 1 bit: one-cycle pulse when animation restart occurs.
REQ-010 SHALL have port valid, output, 1 bit: 1 when registered limit != 31.

Function
REQ-011 SHALL register animation into anim_q each cycle; change detect = (animation != anim_q).
REQ-012 SHALL run a 16-bit prescaler: when run=1, count increments; at count==period, tick asserts for that cycle and count -> 0.
REQ-013 SHALL produce a tick every cycle when period=0 and run=1.
REQ-014 SHALL hold the prescaler count and generate no tick while run=0.
REQ-015 SHALL, on tick with limit in 2..30 and frame < limit-1, set frame <= frame+1, wrap <= 0.
REQ-016 SHALL, on tick with limit in 2..30 and frame >= limit-1, set frame <= 0 and pulse wrap for one cycle (covers limit shrinking below current frame).
REQ-017 SHALL, on tick with limit 0 or 1, keep frame=0 and pulse wrap.
REQ-018 SHALL, while limit==31, force frame=0, valid=0, and suppress wrap; the prescaler keeps running.
REQ-019 SHALL, on change detect, set frame<=0 and prescaler<=0, pulse anim_change, force wrap=0; this takes priority over a same-cycle tick.
REQ-020 SHALL detect change and restart regardless of run.
REQ-021 SHALL register all outputs; frame/wrap/anim_change reflect the tick or change one clk after the causing cycle.
REQ-022 SHALL register valid from limit with one-cycle latency.
REQ-023 SHALL use no arithmetic beyond 5-bit frame increment and 16-bit prescaler increment; frame never exceeds 29.

Reset
REQ-024 SHALL, with reset=1 at a clk edge, set frame=0, prescaler=0, anim_q=0, wrap=0, anim_change=0, valid=0.
REQ-025 SHALL give reset priority over run, tick and change detect; anim_change SHALL NOT pulse on the first cycle after reset if animation==0.
REQ-026 SHALL restart from frame 0 with a full period when reset is asserted mid-sequence.

Verification
REQ-027 SHALL verify: animation=0, limit=10, period=0, run=1 for 12 cycles -> frame 1..9, 0, 1; wrap high only on cycle frame->0.
REQ-028 SHALL verify: period=3, limit=6, run=1 -> frame advances every 4 clks; run=0 for 10 clks -> frame and prescaler frozen; run=1 resumes with remaining count.
REQ-029 SHALL verify: at frame=5, animation 0->2 coinciding with tick -> frame=0, anim_change=1, wrap=0 next cycle; next tick after full period+1 clks.
REQ-030 SHALL verify: animation=12, limit=31 -> valid=0 after one cycle, frame=0, wrap never asserts over 50 ticks.
REQ-031 SHALL verify: limit=1 (or 0), period=0 -> frame stays 0, wrap high every cycle.
REQ-032 SHALL verify: at frame=7, limit changes 10->4 without animation change, tick -> frame=0, wrap=1; reset at frame=3 -> all outputs 0 next cycle.

Source files
------------

// File: rtl/frame_sequencer.sv
// Frame sequencer: steps a frame index through the current animation at a
// prescaled rate, restarting whenever the selected animation changes.
module frame_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  animation,
  input  logic [4:0]  limit,
  input  logic        run,
  input  logic [15:0] period,
  output logic [4:0]  frame,
  output logic        wrap,
  output logic        anim_change,
  output logic        valid
);

  localparam logic [4:0] LIMIT_INVALID = 5'd31;

  logic [3:0]  anim_reg;
  logic [15:0] count_reg, count_next;
  logic [4:0]  frame_reg, frame_next;
  logic        wrap_reg, wrap_next;
  logic        change_reg, change_next;
  logic        valid_reg;
  logic        change;
  logic        tick;
  logic [4:0]  frame_inc;

  assign change    = (animation != anim_reg);
  assign tick      = run && (count_reg == period);
  // frame_inc < limit is frame < limit-1 without a subtractor; frame <= 29 so no overflow
  assign frame_inc = frame_reg + 5'd1;

  always_comb begin
    count_next  = count_reg;
    frame_next  = frame_reg;
    wrap_next   = 1'b0;
    change_next = 1'b0;
    if (change) begin
      count_next  = '0;
      frame_next  = '0;
      change_next = 1'b1;
    end else begin
      if (run) begin
        count_next = tick ? 16'd0 : count_reg + 16'd1;
      end
      if (limit == LIMIT_INVALID) begin
        frame_next = '0;
      end else if (tick) begin
        // limits 0 and 1 also land here: frame_inc >= 1 never fits below them
        if (frame_inc < limit) begin
          frame_next = frame_inc;
        end else begin
          frame_next = '0;
          wrap_next  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      anim_reg   <= '0;
      count_reg  <= '0;
      frame_reg  <= '0;
      wrap_reg   <= 1'b0;
      change_reg <= 1'b0;
      valid_reg  <= 1'b0;
    end else begin
      anim_reg   <= animation;
      count_reg  <= count_next;
      frame_reg  <= frame_next;
      wrap_reg   <= wrap_next;
      change_reg <= change_next;
      valid_reg  <= (limit != LIMIT_INVALID);
    end
  end

  assign frame       = frame_reg;
  assign wrap        = wrap_reg;
  assign anim_change = change_reg;
  assign valid       = valid_reg;

endmodule

// File: tb/tb_frame_sequencer.sv
// Bench for frame_sequencer: a table of per-cycle stimulus rows with hand-derived
// expected outputs; expectations queue on drive and are checked after the edge.
module tb_frame_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  animation;
  logic [4:0]  limit;
  logic        run;
  logic [15:0] period;
  logic [4:0]  frame;
  logic        wrap;
  logic        anim_change;
  logic        valid;

  frame_sequencer dut (
    .clk(clk),
    .reset(reset),
    .animation(animation),
    .limit(limit),
    .run(run),
    .period(period),
    .frame(frame),
    .wrap(wrap),
    .anim_change(anim_change),
    .valid(valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  anim;
    logic [4:0]  lim;
    logic        run;
    logic [15:0] per;
    logic [4:0]  e_frame;
    logic        e_wrap;
    logic        e_chg;
    logic        e_valid;
  } vec_t;

  typedef struct {
    int          row;
    logic [4:0]  frame;
    logic        wrap;
    logic        chg;
    logic        valid;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  function automatic void add(logic rst, logic [3:0] anim, logic [4:0] lim, logic r,
                              logic [15:0] per, logic [4:0] ef, logic ew, logic ec, logic ev);
    vec_t v;
    v.rst = rst; v.anim = anim; v.lim = lim; v.run = r; v.per = per;
    v.e_frame = ef; v.e_wrap = ew; v.e_chg = ec; v.e_valid = ev;
    vecs.push_back(v);
  endfunction

  task automatic check(string name, int row, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s row %0d: got %0d expected %0d", name, row, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;

    // reset has priority over a pending animation change
    add(1, 4'd5, 5'd10, 1, 16'd0, 5'd0, 0, 0, 0);
    add(1, 4'd0, 5'd10, 0, 16'd0, 5'd0, 0, 0, 0);

    // limit 10, tick every cycle: 1..9, 0 (wrap), 1, 2
    for (int k = 1; k <= 12; k++)
      add(0, 4'd0, 5'd10, 1, 16'd0, 5'(k % 10), (k == 10), 0, 1);

    // period 3, limit 6: advance every 4 clks, pause 10 clks, resume with remaining count
    add(1, 4'd0, 5'd6, 1, 16'd3, 5'd0, 0, 0, 0);
    for (int k = 1; k <= 6; k++)
      add(0, 4'd0, 5'd6, 1, 16'd3, 5'(k / 4), 0, 0, 1);
    for (int k = 0; k < 10; k++)
      add(0, 4'd0, 5'd6, 0, 16'd3, 5'd1, 0, 0, 1);
    add(0, 4'd0, 5'd6, 1, 16'd3, 5'd1, 0, 0, 1);
    add(0, 4'd0, 5'd6, 1, 16'd3, 5'd2, 0, 0, 1);
    for (int k = 0; k < 3; k++)
      add(0, 4'd0, 5'd6, 1, 16'd3, 5'd2, 0, 0, 1);
    for (int k = 0; k < 3; k++)
      add(0, 4'd0, 5'd6, 1, 16'd3, 5'd3, 0, 0, 1);

    // mid-sequence reset, then change coinciding with tick at frame 5
    add(1, 4'd0, 5'd10, 1, 16'd3, 5'd0, 0, 0, 0);
    for (int k = 1; k <= 23; k++)
      add(0, 4'd0, 5'd10, 1, 16'd3, 5'(k / 4), 0, 0, 1);
    add(0, 4'd2, 5'd10, 1, 16'd3, 5'd0, 0, 1, 1);
    for (int k = 0; k < 3; k++)
      add(0, 4'd2, 5'd10, 1, 16'd3, 5'd0, 0, 0, 1);
    add(0, 4'd2, 5'd10, 1, 16'd3, 5'd1, 0, 0, 1);
    add(0, 4'd2, 5'd10, 1, 16'd3, 5'd1, 0, 0, 1);
    // change mid-count restarts the prescaler
    add(0, 4'd5, 5'd10, 1, 16'd3, 5'd0, 0, 1, 1);
    for (int k = 0; k < 3; k++)
      add(0, 4'd5, 5'd10, 1, 16'd3, 5'd0, 0, 0, 1);
    add(0, 4'd5, 5'd10, 1, 16'd3, 5'd1, 0, 0, 1);
    // change while paused still restarts
    add(0, 4'd6, 5'd10, 0, 16'd3, 5'd0, 0, 1, 1);

    // limit shrinks 10 -> 4 at frame 7, then reset at frame 3
    add(1, 4'd0, 5'd10, 1, 16'd0, 5'd0, 0, 0, 0);
    for (int k = 1; k <= 7; k++)
      add(0, 4'd0, 5'd10, 1, 16'd0, 5'(k), 0, 0, 1);
    add(0, 4'd0, 5'd4, 1, 16'd0, 5'd0, 1, 0, 1);
    add(0, 4'd0, 5'd4, 1, 16'd0, 5'd1, 0, 0, 1);
    add(0, 4'd0, 5'd4, 1, 16'd0, 5'd2, 0, 0, 1);
    add(0, 4'd0, 5'd4, 1, 16'd0, 5'd3, 0, 0, 1);
    add(1, 4'd0, 5'd4, 1, 16'd0, 5'd0, 0, 0, 0);

    // limit 1 then 0: frame stays 0, wrap every cycle
    for (int k = 0; k < 4; k++)
      add(0, 4'd0, 5'd1, 1, 16'd0, 5'd0, 1, 0, 1);
    for (int k = 0; k < 3; k++)
      add(0, 4'd0, 5'd0, 1, 16'd0, 5'd0, 1, 0, 1);

    // invalid limit: frame forced to 0, no wrap, valid low
    for (int k = 1; k <= 3; k++)
      add(0, 4'd0, 5'd10, 1, 16'd0, 5'(k), 0, 0, 1);
    add(0, 4'd0, 5'd31, 1, 16'd0, 5'd0, 0, 0, 0);
    add(0, 4'd12, 5'd31, 1, 16'd0, 5'd0, 0, 1, 0);
    for (int k = 0; k < 50; k++)
      add(0, 4'd12, 5'd31, 1, 16'd0, 5'd0, 0, 0, 0);
    add(0, 4'd12, 5'd10, 1, 16'd0, 5'd1, 0, 0, 1);
    add(0, 4'd12, 5'd10, 1, 16'd0, 5'd2, 0, 0, 1);

    reset = 1'b1; animation = '0; limit = 5'd10; run = 1'b0; period = '0;

    foreach (vecs[i]) begin
      @(negedge clk);
      reset     = vecs[i].rst;
      animation = vecs[i].anim;
      limit     = vecs[i].lim;
      run       = vecs[i].run;
      period    = vecs[i].per;
      e.row = i; e.frame = vecs[i].e_frame; e.wrap = vecs[i].e_wrap;
      e.chg = vecs[i].e_chg; e.valid = vecs[i].e_valid;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      $display("[TB] row %0d rst=%0d anim=%0d lim=%0d run=%0d per=%0d -> frame=%0d wrap=%0d chg=%0d valid=%0d",
               e.row, vecs[i].rst, vecs[i].anim, vecs[i].lim, vecs[i].run, vecs[i].per,
               frame, wrap, anim_change, valid);
      check("frame", e.row, int'(frame), int'(e.frame));
      check("wrap", e.row, int'(wrap), int'(e.wrap));
      check("anim_change", e.row, int'(anim_change), int'(e.chg));
      check("valid", e.row, int'(valid), int'(e.valid));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
